// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO interrupt port:
// register offsets, bus FSM encoding, reset values.
package gpio_pkg;

    localparam logic [7:0] GPIO_DATA_IN  = 8'h00;
    localparam logic [7:0] GPIO_DATA_OUT = 8'h04;
    localparam logic [7:0] GPIO_DIR      = 8'h08;
    localparam logic [7:0] GPIO_IRQ_EN   = 8'h0C;
    localparam logic [7:0] GPIO_RISE_EN  = 8'h10;
    localparam logic [7:0] GPIO_FALL_EN  = 8'h14;
    localparam logic [7:0] GPIO_PENDING  = 8'h18;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } bus_state_e;

    localparam logic [31:0] GPIO_RST_VAL = 32'h0;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/gpio_irq_port_if.sv
// Request/ready data-bus link between the CPU
// (master) and a memory-mapped peripheral (slave).
interface gpio_irq_port_if #(
    parameter int ADDR_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic [31:0]       rdata;
    logic              ready;
    logic              err;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ready, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ready, err
    );
endinterface

// File: rtl/gpio_edge_detect.sv
// Two-flop pin synchroniser plus history flop;
// qualifies rising/falling edges per pin.
module gpio_edge_detect
    import gpio_pkg::*;
#(
    parameter int N_PINS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_PINS-1:0] pin_i,
    input  logic [N_PINS-1:0] rise_en_i,
    input  logic [N_PINS-1:0] fall_en_i,
    output logic [N_PINS-1:0] sync_o,
    output logic [N_PINS-1:0] edge_o
);

    logic [N_PINS-1:0] s1_q;
    logic [N_PINS-1:0] s2_q;
    logic [N_PINS-1:0] s3_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= N_PINS'(GPIO_RST_VAL);
            s2_q <= N_PINS'(GPIO_RST_VAL);
            s3_q <= N_PINS'(GPIO_RST_VAL);
        end else begin
            s1_q <= pin_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign sync_o = s2_q;
    assign edge_o = (s2_q & ~s3_q & rise_en_i)
                  | (~s2_q & s3_q & fall_en_i);

endmodule

// File: rtl/gpio_irq_port.sv
// Memory-mapped GPIO with edge-triggered sticky
// pending bits and a registered level interrupt.
module gpio_irq_port
    import gpio_pkg::*;
#(
    parameter int N_PINS = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    gpio_irq_port_if.slave    bus,
    input  logic [N_PINS-1:0] gpio_in,
    output logic [N_PINS-1:0] gpio_out,
    output logic [N_PINS-1:0] gpio_oe,
    output logic              irq
);

    localparam logic [N_PINS-1:0] RST_N = N_PINS'(GPIO_RST_VAL);

    bus_state_e        state_q;
    logic              ready_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [N_PINS-1:0] dout_q;
    logic [N_PINS-1:0] dir_q;
    logic [N_PINS-1:0] irqen_q;
    logic [N_PINS-1:0] rise_q;
    logic [N_PINS-1:0] fall_q;
    logic [N_PINS-1:0] pend_q;
    logic              irq_q;

    logic [N_PINS-1:0] sync_v;
    logic [N_PINS-1:0] edge_v;

    gpio_edge_detect #(.N_PINS(N_PINS)) u_edge (
        .clk       (clk),
        .reset     (reset),
        .pin_i     (gpio_in),
        .rise_en_i (rise_q),
        .fall_en_i (fall_q),
        .sync_o    (sync_v),
        .edge_o    (edge_v)
    );

    logic [ADDR_W-1:0] off;
    logic              hit_in, hit_out, hit_dir, hit_ien;
    logic              hit_rise, hit_fall, hit_pend, mapped;
    logic              acc, wr;
    logic [31:0]       bm_full;
    logic [N_PINS-1:0] wmask;
    logic [N_PINS-1:0] wdat;
    logic [N_PINS-1:0] pend_clr;
    logic [31:0]       rd_val;

    assign off      = {bus.addr[ADDR_W-1:2], 2'b00};
    assign hit_in   = off == ADDR_W'(GPIO_DATA_IN);
    assign hit_out  = off == ADDR_W'(GPIO_DATA_OUT);
    assign hit_dir  = off == ADDR_W'(GPIO_DIR);
    assign hit_ien  = off == ADDR_W'(GPIO_IRQ_EN);
    assign hit_rise = off == ADDR_W'(GPIO_RISE_EN);
    assign hit_fall = off == ADDR_W'(GPIO_FALL_EN);
    assign hit_pend = off == ADDR_W'(GPIO_PENDING);
    assign mapped   = hit_in | hit_out | hit_dir | hit_ien
                    | hit_rise | hit_fall | hit_pend;

    assign acc     = (state_q == IDLE) && bus.req;
    assign wr      = acc && bus.we;
    assign bm_full = be_mask(bus.be);
    assign wmask   = bm_full[N_PINS-1:0];
    assign wdat    = bus.wdata[N_PINS-1:0];

    // Only bytes with their enable set may clear pending bits.
    assign pend_clr = (wr && hit_pend) ? (wdat & wmask) : RST_N;

    logic unused_bits;
    assign unused_bits = ^{bus.addr[1:0], bus.wdata, bm_full};

    function automatic logic [N_PINS-1:0] merge(
        input logic [N_PINS-1:0] old
    );
        return (old & ~wmask) | (wdat & wmask);
    endfunction

    always_comb begin
        rd_val = GPIO_RST_VAL;
        unique case (1'b1)
            hit_in:   rd_val = 32'(sync_v);
            hit_out:  rd_val = 32'(dout_q);
            hit_dir:  rd_val = 32'(dir_q);
            hit_ien:  rd_val = 32'(irqen_q);
            hit_rise: rd_val = 32'(rise_q);
            hit_fall: rd_val = 32'(fall_q);
            hit_pend: rd_val = 32'(pend_q);
            default:  rd_val = GPIO_RST_VAL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= GPIO_RST_VAL;
            dout_q  <= RST_N;
            dir_q   <= RST_N;
            irqen_q <= RST_N;
            rise_q  <= RST_N;
            fall_q  <= RST_N;
            pend_q  <= RST_N;
            irq_q   <= 1'b0;
        end else begin
            // A new edge overrides a same-cycle clear.
            pend_q <= (pend_q & ~pend_clr) | edge_v;
            irq_q  <= |(pend_q & irqen_q);
            unique case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        err_q   <= !mapped;
                        rdata_q <= rd_val;
                    end
                    if (wr && hit_out)  dout_q  <= merge(dout_q);
                    if (wr && hit_dir)  dir_q   <= merge(dir_q);
                    if (wr && hit_ien)  irqen_q <= merge(irqen_q);
                    if (wr && hit_rise) rise_q  <= merge(rise_q);
                    if (wr && hit_fall) fall_q  <= merge(fall_q);
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= GPIO_RST_VAL;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign gpio_out  = dout_q;
    assign gpio_oe   = dir_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_gpio_irq_port.sv
// Directed bench for gpio_irq_port: table of
// bus accesses plus edge/irq/reset sequences.
module tb_gpio_irq_port;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] gpio_in;
    logic [N-1:0] gpio_out;
    logic [N-1:0] gpio_oe;
    logic         irq;

    gpio_irq_port_if #(.ADDR_W(8)) bus ();

    gpio_irq_port #(.N_PINS(N), .ADDR_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic we, input logic [7:0] a,
        input logic [31:0] wd, input logic [3:0] be,
        input logic crd, input logic [31:0] rd,
        input logic er
    );
        vec_t v;
        v.we = we; v.addr = a; v.wdata = wd; v.be = be;
        v.chk_rd = crd; v.exp_rd = rd; v.exp_err = er;
        return v;
    endfunction

    task automatic chk(
        input string nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic acc(
        input  logic        we,
        input  logic [7:0]  a,
        input  logic [31:0] wd,
        input  logic [3:0]  be,
        output logic [31:0] rd,
        output logic        er
    );
        @(negedge clk);
        bus.req = 1'b1; bus.we = we; bus.addr = a;
        bus.wdata = wd; bus.be = be;
        @(posedge clk); #1;
        chk($sformatf("ready@%h", a), 32'(bus.ready), 32'd1);
        rd = bus.rdata;
        er = bus.err;
        bus.req = 1'b0; bus.we = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("ready_drop@%h", a), 32'(bus.ready), 32'd0);
        chk($sformatf("rdata_idle@%h", a), bus.rdata, 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        reset = 1'b1;
        gpio_in = '0;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0;
        bus.wdata = '0; bus.be = '0;

        for (int i = 0; i < 7; i++)
            vt.push_back(mk(0, 8'(i * 4), 0, 0, 1, 0, 0));
        vt.push_back(mk(0, 8'h1C, 0, 0, 1, 0, 1));
        vt.push_back(mk(1, 8'h04, 32'hDEAD_BEEF, 4'b0011, 0, 0, 0));
        vt.push_back(mk(1, 8'h08, 32'h0000_00FF, 4'b1111, 0, 0, 0));
        vt.push_back(mk(0, 8'h04, 0, 0, 1, 32'h0000_BEEF, 0));
        vt.push_back(mk(0, 8'h08, 0, 0, 1, 32'h0000_00FF, 0));
        vt.push_back(mk(1, 8'h20, 32'hFFFF_FFFF, 4'b1111, 0, 0, 1));
        vt.push_back(mk(1, 8'h00, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0));
        vt.push_back(mk(0, 8'h00, 0, 0, 1, 32'h0, 0));
        vt.push_back(mk(1, 8'h04, 32'h1234_5678, 4'b1100, 0, 0, 0));
        vt.push_back(mk(0, 8'h05, 0, 0, 1, 32'h0000_BEEF, 0));
        vt.push_back(mk(0, 8'h20, 0, 0, 1, 32'h0, 1));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.ready), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_out", 32'(gpio_out), 0);
        chk("rst_oe", 32'(gpio_oe), 0);
        chk("rst_irq", 32'(irq), 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vt[i]) begin
            acc(vt[i].we, vt[i].addr, vt[i].wdata,
                vt[i].be, rd, er);
            if (vt[i].chk_rd)
                chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(er),
                32'(vt[i].exp_err));
        end
        chk("gpio_out", 32'(gpio_out), 32'h0000_BEEF);
        chk("gpio_oe", 32'(gpio_oe), 32'h0000_00FF);

        // Rising edge on pin 0 -> pending -> irq.
        acc(1, 8'h10, 32'h1, 4'hF, rd, er);
        acc(1, 8'h0C, 32'h1, 4'hF, rd, er);
        @(negedge clk);
        gpio_in[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rise_irq_e%0d", k), 32'(irq),
                32'(k == 4));
        end
        acc(0, 8'h18, 0, 0, rd, er);
        chk("pend_rise", rd, 32'h1);
        acc(0, 8'h00, 0, 0, rd, er);
        chk("data_in", rd, 32'h1);
        acc(1, 8'h18, 32'h1, 4'hF, rd, er);
        chk("irq_after_w1c", 32'(irq), 0);

        // Falling edge on pin 1 while masked.
        acc(1, 8'h0C, 32'h0, 4'hF, rd, er);
        @(negedge clk);
        gpio_in[1] = 1'b1;
        repeat (4) @(posedge clk);
        acc(1, 8'h14, 32'h2, 4'hF, rd, er);
        @(negedge clk);
        gpio_in[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("fall_masked_irq", 32'(irq), 0);
        acc(0, 8'h18, 0, 0, rd, er);
        chk("pend_fall", rd, 32'h2);
        acc(1, 8'h0C, 32'h2, 4'hF, rd, er);
        chk("unmask_irq", 32'(irq), 1);

        // W1C on the same edge that pin 0 rises.
        acc(1, 8'h0C, 32'h3, 4'hF, rd, er);
        @(negedge clk);
        gpio_in[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        gpio_in[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        acc(1, 8'h18, 32'h3, 4'hF, rd, er);
        chk("collide_irq", 32'(irq), 1);
        acc(0, 8'h18, 0, 0, rd, er);
        chk("collide_pend", rd, 32'h1);

        // Byte enable 0 on PENDING clears nothing.
        acc(1, 8'h18, 32'h1, 4'b1110, rd, er);
        acc(0, 8'h18, 0, 0, rd, er);
        chk("pend_be0", rd, 32'h1);

        // Reset while in RESP after a DIR store.
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 8'h08;
        bus.wdata = 32'h0000_F0F0; bus.be = 4'hF;
        @(posedge clk); #1;
        chk("dir_ready", 32'(bus.ready), 1);
        chk("dir_oe", 32'(gpio_oe), 32'h0000_F0F0);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(bus.ready), 0);
        chk("mid_rst_oe", 32'(gpio_oe), 0);
        chk("mid_rst_out", 32'(gpio_out), 0);
        chk("mid_rst_irq", 32'(irq), 0);
        bus.req = 1'b0; bus.we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        acc(0, 8'h08, 0, 0, rd, er);
        chk("dir_after_rst", rd, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/gpio_irq_port.md
Name: gpio_irq_port

Overview:
- Memory-mapped GPIO peripheral. It is the responder on the CPU data-bus request/ready interface.
- It is also the source end of the external-interrupt line the core ORs into its interrupt input (one instance per gpio0_irq / gpio1_irq).
- It synchronises pins, detects programmed edges, latches sticky pending bits, and raises a registered level interrupt until software clears it.

Parameters:
- N_PINS, 16, number of GPIO pins (1..32); register bits above N_PINS-1 read 0 and ignore writes.
- ADDR_W, 8, byte-address width of the local register window.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- bus_req  in  1  access request; held with address/data until bus_ready.
- bus_we  in  1  1=store, 0=load.
- bus_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- bus_wdata  in  32  store data.
- bus_be  in  4  byte enables for stores.
- bus_rdata  out  32  load data, valid while bus_ready=1.
- bus_ready  out  1  one-cycle completion strobe.
- bus_err  out  1  with bus_ready: unmapped address.
- gpio_in  in  N_PINS  raw asynchronous pin inputs.
- gpio_out  out  N_PINS  output data register.
- gpio_oe  out  N_PINS  output enable (= DIR register).
- irq  out  1  level interrupt to core.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high.
- Outputs on reset: bus_rdata=0, bus_ready=0, bus_err=0, gpio_out=0, gpio_oe=0, irq=0.
- Registers on reset: all registers and synchroniser flops are 0. The FSM goes to IDLE.
- Register map (word offsets):
  - 0x00 DATA_IN: RO, synchronised pins.
  - 0x04 DATA_OUT: RW.
  - 0x08 DIR: RW.
  - 0x0C IRQ_EN: RW.
  - 0x10 RISE_EN: RW.
  - 0x14 FALL_EN: RW.
  - 0x18 PENDING: read; write-1-to-clear.
- Unmapped offsets:
  - Reads return 0.
  - Writes are ignored.
  - bus_err=1 with bus_ready.
  - Writes to DATA_IN are ignored with no error.
- Byte enables: stores update only the bytes whose bus_be bit is set. For PENDING, a byte with bus_be=0 clears nothing.
- Handshake FSM, IDLE -> RESP -> IDLE:
  - IDLE: when bus_req=1, capture the access. A write commits at this same edge. Go to RESP.
  - RESP: bus_ready=1 for exactly one cycle. bus_rdata holds the register value sampled at the capturing edge. Go to IDLE unconditionally.
  - The requester must drop bus_req in the cycle it sees bus_ready. If bus_req is still high in IDLE, it is treated as a new access.
  - Throughput: max one access per 2 cycles. Latency: req to ready = 1 clock.
  - bus_rdata returns to 0 when not in RESP.
- Input synchroniser: 2-flop synchroniser per pin (s1, s2), plus a history flop s3.
  - DATA_IN = s2. A pin change is visible 2 edges after it is sampled.
  - rise = s2 & ~s3 & RISE_EN; fall = ~s2 & s3 & FALL_EN.
- Edge detection:
  - Applies regardless of DIR; outputs loop back through gpio_in externally.
  - PENDING[i] is set on rise[i] | fall[i].
  - Both RISE_EN and FALL_EN set means both edges are detected.
- Simultaneous W1C and new edge on the same bit: the set wins and PENDING stays 1. Other bits clear normally.
- irq is a registered output: irq <= |(PENDING & IRQ_EN), so it asserts 1 cycle after PENDING is set.
  - Clearing IRQ_EN masks irq on the next cycle without clearing PENDING.
- Reset asserted mid-transaction: bus_ready drops immediately (async). No write commits after reset is asserted. The requester must reissue.
- Widths:
  - All register storage is N_PINS wide.
  - Reads zero-extend to 32.
  - Writes ignore bits [31:N_PINS].

Decomposition:
- Shared package gpio_pkg holds:
  - the register offset localparams (GPIO_DATA_IN .. GPIO_PENDING);
  - the FSM state encoding (IDLE=1'b0, RESP=1'b1);
  - the reset-value constants.
- One natural sub-module: gpio_edge_detect (N_PINS-wide synchroniser + s3 history + rise/fall qualification). It outputs the synchronised value and the per-pin edge vector.
- Register file, W1C logic, bus FSM and irq register stay in the top module.

Test Plan:
- Reset then read all 7 offsets -> every read returns 0x0000_0000 with bus_ready exactly 1 cycle after bus_req, and bus_err=0. Read 0x1C -> rdata 0, bus_err=1.
- Write DATA_OUT=0xDEAD_BEEF with be=4'b0011, then DIR=0x00FF -> gpio_out=0xBEEF, gpio_oe=0x00FF; read DATA_OUT returns 0x0000_BEEF (N_PINS=16).
- RISE_EN=0x0001, IRQ_EN=0x0001, drive gpio_in[0] 0->1 -> PENDING[0]=1 on the 3rd edge after the change, irq=1 one cycle later. Write PENDING=0x0001 -> irq=0 the cycle after the write commits.
- FALL_EN=0x0002, gpio_in[1] 1->0 with IRQ_EN=0 -> PENDING=0x0002, irq stays 0. Then set IRQ_EN=0x0002 -> irq=1 within 1 cycle.
- Write PENDING=0x0001 on the same edge bit0 sees a rising edge -> PENDING[0] remains 1 and irq stays 1.
- Assert reset while in RESP after a store to DIR -> bus_ready=0 immediately, all outputs 0. After release, DIR reads 0.
